// File: rtl/cnn_pkg.sv
// Shared pixel-stream types and defaults for the CNN front-end blocks.
// Pure declarations; no logic, no latency, no flow control.
// Included before any block that imports it.
package cnn_pkg;

    localparam int CNN_PIX_W  = 4;
    localparam int CNN_IN_DIM = 16;

    typedef logic [CNN_PIX_W-1:0] pix_t;

    localparam pix_t CNN_PAD_VALUE = 4'd1;

    // True when a row/col index sits on the outer ring of a dim x dim frame.
    function automatic logic on_edge(input int unsigned idx, input int unsigned dim);
        return (idx == 0) || (idx == dim - 1);
    endfunction

endpackage

// File: rtl/unpad_pos_counter.sv
// Raster position tracker for a padded frame: border / last-interior / frame-end decode.
// Latency: decodes are combinational on the current position; position advances on i_adv.
// Backpressure: none of its own; i_adv is the upstream handshake.
module unpad_pos_counter
    import cnn_pkg::*;
#(
    parameter int IN_DIM = CNN_IN_DIM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_adv,
    output logic o_border,
    output logic o_last_int,
    output logic o_frame_end
);

    localparam int CW = $clog2(IN_DIM);
    localparam logic [CW-1:0] MAX      = CW'(IN_DIM - 1);
    localparam logic [CW-1:0] LAST_INT = CW'(IN_DIM - 2);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_col_wrap;

    assign w_col_wrap = (r_col == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= (r_row == MAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_border    = on_edge(32'(r_row), IN_DIM) || on_edge(32'(r_col), IN_DIM);
    assign o_last_int  = (r_row == LAST_INT) && (r_col == LAST_INT);
    assign o_frame_end = (r_row == MAX) && w_col_wrap;

endmodule

// File: rtl/unpad_stream.sv
// Strips the 1-pixel border from a padded raster stream (optional border check: UNPAD_BORDER_CHECK_EN).
// Latency: 1 cycle from accepted interior pixel to m_valid; frame_done 1 cycle after last input.
// Backpressure: single output register, s_ready = !m_valid || m_ready; border pixels obey it too.
module unpad_stream
    import cnn_pkg::*;
#(
    parameter int               PIX_W     = CNN_PIX_W,
    parameter int               IN_DIM    = CNN_IN_DIM,
    parameter logic [PIX_W-1:0] PAD_VALUE = CNN_PAD_VALUE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic             frame_done,
    output logic             pad_err
);

    logic             w_accept;
    logic             w_push;
    logic             w_border;
    logic             w_last_int;
    logic             w_frame_end;

    logic             r_m_valid;
    logic [PIX_W-1:0] r_m_data;
    logic             r_m_last;
    logic             r_frame_done;

    assign s_ready  = !r_m_valid || m_ready;
    assign w_accept = s_valid && s_ready;
    assign w_push   = w_accept && !w_border;

    unpad_pos_counter #(
        .IN_DIM      (IN_DIM)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_adv       (w_accept),
        .o_border    (w_border),
        .o_last_int  (w_last_int),
        .o_frame_end (w_frame_end)
    );

    // A push in the same cycle as a pop keeps the register full: full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_push) begin
            r_m_valid <= 1'b1;
            r_m_data  <= s_data;
            r_m_last  <= w_last_int;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_frame_end;
        end
    end

`ifdef UNPAD_BORDER_CHECK_EN
    logic r_at_start;
    logic r_pad_err;
    logic w_mismatch;

    assign w_mismatch = (s_data != PAD_VALUE);

    // r_at_start marks that the next accepted pixel is (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_at_start <= 1'b1;
            r_pad_err  <= 1'b0;
        end else if (w_accept) begin
            r_at_start <= w_frame_end;
            if (r_at_start) begin
                r_pad_err <= w_mismatch;
            end else if (w_border && w_mismatch) begin
                r_pad_err <= 1'b1;
            end
        end
    end

    assign pad_err = r_pad_err;
`else
    assign pad_err = 1'b0;
`endif

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_last     = r_m_last;
    assign frame_done = r_frame_done;

endmodule

// File: doc/unpad_stream.md
UNPAD_STREAM -- requirements
Module: unpad_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 4, pixel width in bits.
REQ-002 SHALL have parameter IN_DIM, default 16, padded frame side in pixels; interior side is IN_DIM-2.
REQ-003 SHALL have parameter PAD_VALUE, default 4'd1, expected border pixel value.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  padded pixel valid.
REQ-007 SHALL have port s_ready  output  1  padded pixel accepted when s_valid and s_ready.
REQ-008 SHALL have port s_data  input  PIX_W  padded pixel, raster order, row-major, (0,0) first.
REQ-009 SHALL have port m_valid  output  1  interior pixel valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  PIX_W  interior pixel.
REQ-012 SHALL have port m_last  output  1  high with interior pixel (IN_DIM-2, IN_DIM-2), the last of the frame.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when padded pixel (IN_DIM-1, IN_DIM-1) is accepted.
REQ-014 SHALL have port pad_err  output  1  border mismatch flag (see Configuration).

Function
REQ-015 SHALL keep row and col counters, 0..IN_DIM-1; col increments per accepted input; at IN_DIM-1 col wraps to 0 and row increments; at (IN_DIM-1, IN_DIM-1) both wrap to 0.
REQ-016 SHALL classify accepted pixel as border when row or col equals 0 or IN_DIM-1; border pixels are consumed and dropped.
REQ-017 SHALL load accepted interior pixels into a single output register: m_valid set next cycle, m_data = s_data, latency 1 cycle.
REQ-018 SHALL drive s_ready = !m_valid || m_ready (combinational); border pixels obey the same rule.
REQ-019 SHALL clear m_valid on m_ready && m_valid unless a new interior pixel is accepted the same cycle (simultaneous pop and push keeps m_valid high, full throughput).
REQ-020 SHALL hold m_data, m_last stable while m_valid && !m_ready.
REQ-021 SHALL assert m_last only for interior pixel (IN_DIM-2, IN_DIM-2); exactly (IN_DIM-2)^2 outputs per frame.
REQ-022 SHALL pulse frame_done the cycle after the last padded pixel is accepted, independent of m_ready.
REQ-023 SHALL accept back-to-back frames with no idle cycle between them.

Reset
REQ-024 SHALL on rst_n low asynchronously set row=0, col=0, m_valid=0, m_data=0, m_last=0, frame_done=0, pad_err=0.
REQ-025 SHALL, on reset mid-frame, discard the partial frame; the next accepted pixel is (0,0).

Configuration
REQ-026 SHALL with UNPAD_BORDER_CHECK_EN defined compare every accepted border pixel to PAD_VALUE and set pad_err on mismatch.
REQ-027 SHALL with UNPAD_BORDER_CHECK_EN defined hold pad_err sticky for the frame, clearing it when pixel (0,0) is accepted (then set if (0,0) mismatches).
REQ-028 SHALL without UNPAD_BORDER_CHECK_EN keep port pad_err, tied constant 0, no compare logic.

Structure
REQ-029 SHALL take PIX_W, IN_DIM, PAD_VALUE defaults and the pixel typedef from shared package cnn_pkg.
REQ-030 SHALL place row/col counting and border/last/frame-end decode in sub-module unpad_pos_counter.

Verification
REQ-031 Frame of 256 pixels, value = (row*16+col)%16 except border=1, m_ready=1 -> 196 outputs, first m_data=1 ((1,1)=17%16), m_last on 196th only, frame_done one pulse, pad_err=0.
REQ-032 Same frame with m_ready toggling 1010... -> identical 196-value sequence, no drops/duplicates, m_data stable while stalled.
REQ-033 Two frames back-to-back, s_valid always 1 -> 392 outputs, two m_last, two frame_done pulses 256 cycles apart.
REQ-034 rst_n low after 100 accepted pixels, then full frame -> output matches REQ-031 exactly, no stale pixel.
REQ-035 With UNPAD_BORDER_CHECK_EN, border pixel (0,5)=4'd7 -> pad_err high from next cycle until (0,0) of following clean frame accepted; without macro pad_err stays 0.
